fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch controller that sits on the driving side of the program-counter register. It reads the current PC and issues single-beat requests to instruction memory with a ready handshake. It hands each fetched word to decode with a valid/ready handshake, and drives the register's load port (PCIn/PCEn) with PC+4 or a branch/jump redirect target.

## Interface
- PC_STEP, 4: sequential increment added to PC after each fetched word.
- CLK  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-low; sampled on posedge CLK.
- PC  input  32  current PC from the program-counter register.
- PCIn  output  32  next-PC value for the register.
- PCEn  output  1  load strobe for the register; one-cycle pulse.
- IReq  output  1  instruction-memory request.
- IAddr  output  32  request address; equals PC while IReq=1.
- IReady  input  1  memory completes the request at a posedge where IReq=1.
- IData  input  32  instruction word; valid when IReady=1.
- Instr  output  32  fetched instruction to decode.
- InstrValid  output  1  Instr holds a live word.
- InstrReady  input  1  decode accepts at a posedge where InstrValid=1.
- Redirect  input  1  flush plus PC change request; one-cycle pulse.
- RedirectTarget  input  32  new PC; bits [1:0] are forced to 0 before use.

## Operation
- States: IDLE, REQ, HOLD, WAIT. A separate `pend` flag and a 32-bit `pend_tgt` register.
- Reset (reset=0 at posedge):
  - state=IDLE, pend=0.
  - IReq=0, PCEn=0, PCIn=0, InstrValid=0, Instr=0.
  - Reset overrides everything, including an in-flight request. The memory side must tolerate an abandoned request.
- IDLE: go to REQ on the next posedge, unless Redirect=1.
- REQ:
  - IReq=1, IAddr=PC. IAddr stays stable until completion.
  - On IReady=1 with pend=0: Instr<=IData, InstrValid<=1, PCEn<=1, PCIn<=PC+PC_STEP (mod 2^32), go to HOLD.
  - On IReady=1 with pend=1: discard IData, PCEn<=1, PCIn<=pend_tgt, pend<=0, go to WAIT.
  - Redirect in REQ, with or without IReady: pend<=1, pend_tgt<=target. Because of this, a redirect together with IReady takes the discard path. A later redirect overwrites pend_tgt.
- HOLD:
  - InstrValid=1 and Instr stays stable.
  - On InstrReady=1: InstrValid<=0, go to REQ.
- WAIT: one cycle so the register loads PCIn. Then go to REQ.
- Redirect in IDLE, HOLD or WAIT:
  - PCEn<=1, PCIn<=target, InstrValid<=0, go to WAIT.
  - Redirect beats InstrReady at the same edge, so that instruction counts as flushed.
- PCEn is 1 for exactly one cycle per load. PCIn holds its value when PCEn=0.
- Word alignment: PCIn[1:0] is always 0.

## Timing
- All outputs except IAddr are registered. IAddr is PC passed through combinationally.
- Fetch latency: request at edge E with IReady → InstrValid=1 and PCEn=1 in the cycle after E. The register holds PC+4 after E+1.
- Best-case throughput is one word per 2 cycles: REQ (IReady=1 immediately) → HOLD (InstrReady=1 immediately) → REQ.
- Accept at edge E+1 coincides with the PC load, so the next REQ presents the updated PC.
- Redirect outside REQ → PCEn pulse in the next cycle → WAIT → REQ. The first request to the target is issued 2 cycles after the redirect edge.
- Redirect in REQ → the request completes unchanged → PCEn with the target → WAIT → REQ.
- IReady=0 indefinitely keeps REQ and IAddr stable. There is no timeout.

## Structure
- Shared package cpu_fetch_pkg holds:
  - the state enum (IDLE, REQ, HOLD, WAIT; 2-bit encoding);
  - the PC_STEP constant;
  - the 32'b0 reset-PC constant, which matches the program-counter register's reset value.
- Single flat module with no sub-module. The adder and redirect muxing are too small to split out.

## Test plan
- Reset then straight-line fetch:
  - reset low 2 cycles, PC register at 0, IReady and InstrReady tied high.
  - IAddr sequence 0, 4, 8, 12. One PCEn pulse per word, PCIn 4, 8, 12. InstrValid asserted every other cycle.
- Memory stall:
  - IReady low for 5 cycles at PC=0x40.
  - IReq and IAddr=0x40 held for 5 cycles. Instr=IData on the 6th edge. Exactly one PCEn with PCIn=0x44.
- Redirect during HOLD with simultaneous InstrReady:
  - Target 0x1003.
  - InstrValid drops, PCIn=0x1000. Next IAddr=0x1000. The held word is not re-presented.
- Redirect during a stalled REQ:
  - Target 0x200, IReady arrives 3 cycles later.
  - That IData is never shown on Instr. PCIn=0x200 then WAIT. Next IAddr=0x200.
- Two redirects during one REQ (0x300, then 0x400): only 0x400 is loaded.
- Reset mid-fetch:
  - reset low during REQ with IReady=1.
  - All outputs are 0 the next cycle and the captured word is discarded. Fetch restarts at IAddr=0.

Source files
------------

// File: rtl/cpu_fetch_pkg.sv
// Shared fetch-path definitions: controller state encoding, PC step and reset PC.
package cpu_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        WAIT = 2'd3
    } fetch_state_t;

    localparam logic [31:0] PC_STEP  = 32'd4;
    // Must match the program-counter register's own reset value.
    localparam logic [31:0] RESET_PC = 32'b0;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: single-beat memory requests, decode handoff, PC load/redirect.
// Latency: word reaches decode one cycle after memory completion; stalls on IReady=0 or InstrReady=0.
module fetch_ctrl #(
    parameter logic [31:0] PC_STEP = cpu_fetch_pkg::PC_STEP
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [31:0] PC,
    output logic [31:0] PCIn,
    output logic        PCEn,
    output logic        IReq,
    output logic [31:0] IAddr,
    input  logic        IReady,
    input  logic [31:0] IData,
    output logic [31:0] Instr,
    output logic        InstrValid,
    input  logic        InstrReady,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget
);
    import cpu_fetch_pkg::*;

    fetch_state_t state, state_n;
    logic        pend, pend_n;
    logic [31:0] pend_tgt, pend_tgt_n;
    logic        ireq_n, pcen_n, valid_n;
    logic [31:0] pcin_n, instr_n, redir_tgt;

    assign redir_tgt = word_align(RedirectTarget);
    assign IAddr     = PC;

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state      <= IDLE;
            pend       <= 1'b0;
            pend_tgt   <= RESET_PC;
            IReq       <= 1'b0;
            PCEn       <= 1'b0;
            PCIn       <= RESET_PC;
            InstrValid <= 1'b0;
            Instr      <= 32'b0;
        end else begin
            state      <= state_n;
            pend       <= pend_n;
            pend_tgt   <= pend_tgt_n;
            IReq       <= ireq_n;
            PCEn       <= pcen_n;
            PCIn       <= pcin_n;
            InstrValid <= valid_n;
            Instr      <= instr_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: state_n = Redirect ? WAIT : REQ;
            REQ: begin
                if (IReady) state_n = (pend || Redirect) ? WAIT : HOLD;
            end
            HOLD: begin
                if (Redirect)        state_n = WAIT;
                else if (InstrReady) state_n = REQ;
            end
            WAIT: state_n = Redirect ? WAIT : REQ;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        pend_n     = pend;
        pend_tgt_n = pend_tgt;
        pcen_n     = 1'b0;
        pcin_n     = PCIn;
        valid_n    = InstrValid;
        instr_n    = Instr;
        ireq_n     = (state_n == REQ);
        if (state == REQ) begin
            // The in-flight request is never cancelled; a redirect is parked until it completes.
            if (Redirect) begin
                pend_n     = 1'b1;
                pend_tgt_n = redir_tgt;
            end
            if (IReady) begin
                pcen_n = 1'b1;
                if (pend || Redirect) begin
                    pcin_n = Redirect ? redir_tgt : pend_tgt;
                    pend_n = 1'b0;
                end else begin
                    pcin_n  = word_align(PC + PC_STEP);
                    instr_n = IData;
                    valid_n = 1'b1;
                end
            end
        end else if (Redirect) begin
            pcen_n  = 1'b1;
            pcin_n  = redir_tgt;
            valid_n = 1'b0;
        end else if (state == HOLD && InstrReady) begin
            valid_n = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl with a transaction-level reference model and closed-loop PC register.
module tb_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        reset;
    logic [31:0] PC;
    logic [31:0] PCIn;
    logic        PCEn;
    logic        IReq;
    logic [31:0] IAddr;
    logic        IReady;
    logic [31:0] IData;
    logic [31:0] Instr;
    logic        InstrValid;
    logic        InstrReady;
    logic        Redirect;
    logic [31:0] RedirectTarget;

    int checks   = 0;
    int failures = 0;

    fetch_ctrl dut (
        .CLK(CLK), .reset(reset), .PC(PC), .PCIn(PCIn), .PCEn(PCEn),
        .IReq(IReq), .IAddr(IAddr), .IReady(IReady), .IData(IData),
        .Instr(Instr), .InstrValid(InstrValid), .InstrReady(InstrReady),
        .Redirect(Redirect), .RedirectTarget(RedirectTarget)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // Reference model: a request is outstanding, a word is presented, or a PC load is settling.
    bit          m_fetching, m_presenting, m_settling;
    bit          m_pcen;
    logic [31:0] m_pcin, m_instr;
    logic [31:0] m_parked[$];

    task automatic model_step();
        bit          load_now   = m_pcen;
        logic [31:0] load_val   = m_pcin;
        logic [31:0] tgt        = {RedirectTarget[31:2], 2'b00};
        if (!reset) begin
            m_fetching = 0; m_presenting = 0; m_settling = 0;
            m_pcen = 0; m_pcin = 0; m_instr = 0;
            m_parked.delete();
            PC = 32'h0;
            return;
        end
        m_pcen = 0;
        if (m_fetching) begin
            if (Redirect) begin
                m_parked.delete();
                m_parked.push_back(tgt);
            end
            if (IReady) begin
                m_fetching = 0;
                m_pcen = 1;
                if (m_parked.size() != 0) begin
                    m_pcin = m_parked.pop_front();
                    m_settling = 1;
                end else begin
                    m_pcin = (PC + 32'd4) & ~32'd3;
                    m_instr = IData;
                    m_presenting = 1;
                end
            end
        end else if (Redirect) begin
            m_pcen = 1; m_pcin = tgt;
            m_presenting = 0; m_settling = 1;
        end else if (m_presenting) begin
            if (InstrReady) begin
                m_presenting = 0; m_fetching = 1;
            end
        end else begin
            m_settling = 0; m_fetching = 1;
        end
        if (load_now) PC = load_val;
    endtask

    initial begin
        reset = 0; PC = 0; IReady = 0; IData = 0; InstrReady = 0;
        Redirect = 0; RedirectTarget = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge CLK);
            if (c < 14) begin
                reset = (c >= 2);
                IReady = 1; InstrReady = 1; Redirect = 0;
            end else begin
                int stall_bias = (c < 1500) ? 40 : 85;
                reset = ($urandom_range(0, 99) >= 2);
                IReady = ($urandom_range(0, 99) >= stall_bias);
                InstrReady = ($urandom_range(0, 99) < 60);
                Redirect = ($urandom_range(0, 99) < 12);
            end
            IData = $urandom;
            RedirectTarget = $urandom;
            @(posedge CLK);
            #1;
            model_step();
            #1;
            chk("ireq", {31'b0, IReq}, {31'b0, m_fetching});
            chk("iaddr", IAddr, PC);
            chk("pcen", {31'b0, PCEn}, {31'b0, m_pcen});
            chk("pcin", PCIn, m_pcin);
            chk("pcin_align", {30'b0, PCIn[1:0]}, 32'b0);
            chk("valid", {31'b0, InstrValid}, {31'b0, m_presenting});
            chk("instr", Instr, m_instr);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
